// File: rtl/rv_pkg.sv
// +--------------------------------------------------------------------------+
// | rv_pkg: opcodes, ALUSel codes and operand-source enums for rvcore-lite.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic {A_RS1 = 1'b0, A_PC = 1'b1} a_sel_e;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} b_sel_e;
endpackage
`default_nettype wire

// File: rtl/id_ex_decode.sv
// +--------------------------------------------------------------------------+
// | id_ex_decode: opcode/funct fields to operand selects and ALUSel code.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
module id_ex_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output a_sel_e     a_sel,
  output b_sel_e     b_sel,
  output logic [3:0] alusel,
  output logic       reg_we,
  output logic       illegal
);
  logic f7_op;
  logic f7_imm;

  // Only the add/sub and shift-right slots use funct7b5 as an opcode bit.
  assign f7_op  = funct7b5 & ((funct3 == 3'b000) | (funct3 == 3'b101));
  assign f7_imm = funct7b5 & (funct3 == 3'b101);

  always_comb begin
    a_sel   = A_RS1;
    b_sel   = B_RS2;
    alusel  = ALU_ADD;
    reg_we  = 1'b1;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:     alusel = {f7_op, funct3};
      OPC_OP_IMM: begin
        b_sel  = B_IMM;
        alusel = {f7_imm, funct3};
      end
      OPC_LUI: begin
        b_sel  = B_IMM;
        alusel = ALU_PASSB;
      end
      OPC_AUIPC: begin
        a_sel = A_PC;
        b_sel = B_IMM;
      end
      OPC_LOAD:   b_sel = B_IMM;
      OPC_STORE: begin
        b_sel  = B_IMM;
        reg_we = 1'b0;
      end
      OPC_BRANCH: begin
        alusel = ALU_SUB;
        reg_we = 1'b0;
      end
      OPC_JAL, OPC_JALR: begin
        a_sel = A_PC;
        b_sel = B_FOUR;
      end
      default: begin
        illegal = 1'b1;
        reg_we  = 1'b0;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with decode, operand select and     |
// | MEM/WB forwarding feeding the ALU.  Revision: 1.0                        |
// +--------------------------------------------------------------------------+
`default_nettype none
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            mem_fwd_we,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_we,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alusel
);
  localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

  a_sel_e     dec_a_sel;
  b_sel_e     dec_b_sel;
  logic [3:0] dec_alusel;
  logic       dec_reg_we;
  logic       dec_illegal;

  id_ex_decode u_decode (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .funct7b5 (id_funct7b5),
    .a_sel    (dec_a_sel),
    .b_sel    (dec_b_sel),
    .alusel   (dec_alusel),
    .reg_we   (dec_reg_we),
    .illegal  (dec_illegal)
  );

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  a_sel_e          a_sel_q;
  b_sel_e          b_sel_q;
  logic [3:0]      alusel_q;
  logic            reg_we_q;
  logic            illegal_q;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // x0 is never forwarded; MEM is younger than WB so it takes priority.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_q != 5'd0 && mem_fwd_we && mem_fwd_rd == rs1_q)     fwd_rs1 = mem_fwd_data;
    else if (rs1_q != 5'd0 && wb_fwd_we && wb_fwd_rd == rs1_q)  fwd_rs1 = wb_fwd_data;
    fwd_rs2 = rs2_data_q;
    if (rs2_q != 5'd0 && mem_fwd_we && mem_fwd_rd == rs2_q)     fwd_rs2 = mem_fwd_data;
    else if (rs2_q != 5'd0 && wb_fwd_we && wb_fwd_rd == rs2_q)  fwd_rs2 = wb_fwd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      a_sel_q    <= A_RS1;
      b_sel_q    <= B_RS2;
      alusel_q   <= ALU_ADD;
      reg_we_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      // Refresh operand data so a producer retiring mid-stall is not lost.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else begin
      valid_q    <= id_valid;
      pc_q       <= id_pc;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      a_sel_q    <= dec_a_sel;
      b_sel_q    <= dec_b_sel;
      alusel_q   <= dec_alusel;
      reg_we_q   <= dec_reg_we;
      illegal_q  <= dec_illegal;
    end
  end

  always_comb begin
    ex_a = fwd_rs1;
    if (a_sel_q == A_PC) ex_a = pc_q;
    case (b_sel_q)
      B_IMM:   ex_b = imm_q;
      B_FOUR:  ex_b = C_FOUR;
      default: ex_b = fwd_rs2;
    endcase
  end

  assign ex_valid   = valid_q;
  assign ex_rd      = rd_q;
  assign ex_reg_we  = reg_we_q & valid_q;
  assign ex_illegal = illegal_q & valid_q;
  assign ex_alusel  = alusel_q;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage: scoreboard bench for the ID/EX stage.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
module tb_id_ex_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_reg_we, ex_illegal;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_alusel;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_illegal(ex_illegal),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alusel(ex_alusel)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t e, got;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t outs();
    return '{ex_valid, ex_rd, ex_reg_we, ex_a, ex_b, ex_alusel, ex_illegal};
  endfunction

  task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] r1, r2, rd,
                       input logic [31:0] d1, d2, imm, input logic [6:0] opc,
                       input logic [2:0] f3, input logic f7);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_opcode = opc; id_funct3 = f3; id_funct7b5 = f7;
  endtask

  task automatic fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                     input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
    mem_fwd_we = mwe; mem_fwd_rd = mrd; mem_fwd_data = md;
    wb_fwd_we = wwe; wb_fwd_rd = wrd; wb_fwd_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 7'h0, 3'h0, 1'b0);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    sb.push_back('0);
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL reset got=%h exp=%h", got, e); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_r_type();
    instr(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'h0, OPC_OP, 3'b000, 1'b1);
    sb.push_back('{1'b1, 5'd3, 1'b1, 32'd10, 32'd3, 4'b1000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL r_sub got=%h exp=%h", got, e); end
    // f7b5 must be ignored for AND
    instr(1'b1, 32'h44, 5'd1, 5'd2, 5'd4, 32'hF0F0, 32'h0FF0, 32'h0, OPC_OP, 3'b111, 1'b1);
    sb.push_back('{1'b1, 5'd4, 1'b1, 32'hF0F0, 32'h0FF0, 4'b0111, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL r_and_f7 got=%h exp=%h", got, e); end
  endtask

  task automatic test_op_imm();
    instr(1'b1, 32'h48, 5'd1, 5'd9, 5'd5, 32'd5, 32'h77, 32'hFFFF_FFFF, OPC_OP_IMM, 3'b000, 1'b1);
    sb.push_back('{1'b1, 5'd5, 1'b1, 32'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL addi_f7 got=%h exp=%h", got, e); end
    instr(1'b1, 32'h4C, 5'd1, 5'd0, 5'd6, 32'h8000_0000, 32'h0, 32'd3, OPC_OP_IMM, 3'b101, 1'b1);
    sb.push_back('{1'b1, 5'd6, 1'b1, 32'h8000_0000, 32'd3, 4'b1101, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL srai got=%h exp=%h", got, e); end
  endtask

  task automatic test_forwarding();
    instr(1'b1, 32'h50, 5'd5, 5'd5, 5'd8, 32'd1, 32'd2, 32'h0, OPC_OP, 3'b000, 1'b0);
    tick();
    fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    #1;
    sb.push_back('{1'b1, 5'd8, 1'b1, 32'hAA, 32'hAA, 4'b0000, 1'b0});
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL fwd_mem_wins got=%h exp=%h", got, e); end
    fwd(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
    #1;
    sb.push_back('{1'b1, 5'd8, 1'b1, 32'hBB, 32'hBB, 4'b0000, 1'b0});
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL fwd_wb got=%h exp=%h", got, e); end
    fwd(1'b1, 5'd6, 32'hAA, 1'b1, 5'd4, 32'hBB);
    #1;
    sb.push_back('{1'b1, 5'd8, 1'b1, 32'd1, 32'd2, 4'b0000, 1'b0});
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL fwd_none got=%h exp=%h", got, e); end
    // x0 never forwarded
    instr(1'b1, 32'h54, 5'd0, 5'd0, 5'd9, 32'h11, 32'h22, 32'h0, OPC_OP, 3'b000, 1'b0);
    fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    sb.push_back('{1'b1, 5'd9, 1'b1, 32'h11, 32'h22, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL fwd_x0 got=%h exp=%h", got, e); end
    // immediate operand is not forwarded even if rs2 field matches
    instr(1'b1, 32'h58, 5'd5, 5'd5, 5'd10, 32'h3, 32'h4, 32'h123, OPC_OP_IMM, 3'b000, 1'b0);
    fwd(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0);
    sb.push_back('{1'b1, 5'd10, 1'b1, 32'hAA, 32'h123, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL fwd_imm got=%h exp=%h", got, e); end
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_stall();
    instr(1'b1, 32'h60, 5'd7, 5'd0, 5'd11, 32'h99, 32'h0, 32'h0, OPC_OP, 3'b000, 1'b0);
    tick();
    stall = 1'b1;
    instr(1'b1, 32'h64, 5'd1, 5'd2, 5'd12, 32'h5555, 32'h6666, 32'h0, OPC_OP, 3'b100, 1'b0);
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    tick();
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    sb.push_back('{1'b1, 5'd11, 1'b1, 32'h1234, 32'h0, 4'b0000, 1'b0});
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL stall_cycle1 got=%h exp=%h", got, e); end
    sb.push_back('{1'b1, 5'd11, 1'b1, 32'h1234, 32'h0, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", got, e); end
    stall = 1'b0;
    sb.push_back('{1'b1, 5'd12, 1'b1, 32'h5555, 32'h6666, 4'b0100, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL stall_release got=%h exp=%h", got, e); end
  endtask

  task automatic test_flush_bubble();
    flush = 1'b1; stall = 1'b1;
    instr(1'b1, 32'h70, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 32'h0, OPC_OP, 3'b000, 1'b0);
    tick();
    n_tests++;
    if ({ex_valid, ex_reg_we, ex_illegal} !== 3'b000) begin
      n_fail++; $display("FAIL flush_stall got=%b exp=000", {ex_valid, ex_reg_we, ex_illegal});
    end
    flush = 1'b0; stall = 1'b0;
    instr(1'b0, 32'h74, 5'd1, 5'd2, 5'd14, 32'h1, 32'h2, 32'h0, OPC_OP, 3'b000, 1'b0);
    tick();
    n_tests++;
    if ({ex_valid, ex_reg_we} !== 2'b00) begin
      n_fail++; $display("FAIL bubble got=%b exp=00", {ex_valid, ex_reg_we});
    end
  endtask

  task automatic test_back_to_back();
    // JAL, JALR, AUIPC, STORE, BRANCH, LOAD on consecutive cycles
    instr(1'b1, 32'h100, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h800, OPC_JAL, 3'b000, 1'b0);
    sb.push_back('{1'b1, 5'd1, 1'b1, 32'h100, 32'd4, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL jal got=%h exp=%h", got, e); end
    instr(1'b1, 32'h104, 5'd3, 5'd0, 5'd1, 32'h900, 32'h0, 32'h8, OPC_JALR, 3'b000, 1'b0);
    sb.push_back('{1'b1, 5'd1, 1'b1, 32'h104, 32'd4, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL jalr got=%h exp=%h", got, e); end
    instr(1'b1, 32'h200, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h1000, OPC_AUIPC, 3'b000, 1'b0);
    sb.push_back('{1'b1, 5'd2, 1'b1, 32'h200, 32'h1000, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL auipc got=%h exp=%h", got, e); end
    instr(1'b1, 32'h204, 5'd3, 5'd4, 5'd5, 32'h300, 32'h44, 32'h10, OPC_STORE, 3'b010, 1'b0);
    sb.push_back('{1'b1, 5'd5, 1'b0, 32'h300, 32'h10, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL store got=%h exp=%h", got, e); end
    instr(1'b1, 32'h208, 5'd3, 5'd4, 5'd6, 32'h30, 32'h44, 32'h10, OPC_BRANCH, 3'b000, 1'b0);
    sb.push_back('{1'b1, 5'd6, 1'b0, 32'h30, 32'h44, 4'b1000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL branch got=%h exp=%h", got, e); end
    instr(1'b1, 32'h20C, 5'd3, 5'd4, 5'd7, 32'h400, 32'h44, 32'hFFFF_FFFC, OPC_LOAD, 3'b010, 1'b0);
    sb.push_back('{1'b1, 5'd7, 1'b1, 32'h400, 32'hFFFF_FFFC, 4'b0000, 1'b0});
    tick();
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL load got=%h exp=%h", got, e); end
    instr(1'b1, 32'h210, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'hABCD_E000, OPC_LUI, 3'b000, 1'b0);
    tick();
    n_tests++;
    if ({ex_b, ex_alusel, ex_reg_we} !== {32'hABCD_E000, 4'b1111, 1'b1}) begin
      n_fail++; $display("FAIL lui got b=%h sel=%b we=%b exp b=abcde000 sel=1111 we=1",
                         ex_b, ex_alusel, ex_reg_we);
    end
  endtask

  task automatic test_illegal();
    instr(1'b1, 32'h300, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 7'h7F, 3'b000, 1'b1);
    tick();
    n_tests++;
    if ({ex_valid, ex_illegal, ex_reg_we, ex_alusel} !== {1'b1, 1'b1, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL illegal got v=%b ill=%b we=%b sel=%b exp v=1 ill=1 we=0 sel=0000",
                         ex_valid, ex_illegal, ex_reg_we, ex_alusel);
    end
  endtask

  task automatic test_async_reset();
    instr(1'b1, 32'h400, 5'd0, 5'd0, 5'd15, 32'h0, 32'h0, 32'h0, OPC_JAL, 3'b000, 1'b0);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    sb.push_back('0);
    e = sb.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", got, e); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_op_imm();
    test_forwarding();
    test_stall();
    test_flush_bubble();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
